keypad: RTL and testbench

Synchronous scanner for a 4-row x 3-column matrix keypad, used as the ATM processor's key input front end.
- Each transition on start launches one scan pass: rows are driven one-hot in turn and cols is sampled.
- Reports the first pressed key as zero-extended 32-bit row and column indices, qualified by dataReady.
- Outputs are 32-bit so the processor can read them directly as register words.

---
 rtl/keypad_pkg.sv | 30 +++
 rtl/keypad_sync.sv | 27 ++
 rtl/keypad.sv | 135 +++++++++++++
 tb/tb_keypad.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x3 matrix keypad scanner.
package keypad_pkg;

  localparam int unsigned NUM_ROWS  = 4;
  localparam int unsigned NUM_COLS  = 3;
  localparam int unsigned ROW_IDX_W = $clog2(NUM_ROWS);

  // Reported on both index outputs when a full pass finds no key.
  localparam logic [31:0] NOT_FOUND = 32'hFFFF_FFFF;

  localparam logic [ROW_IDX_W-1:0] ROW_LAST = ROW_IDX_W'(NUM_ROWS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSample,
    StDone
  } state_e;

  // Index of the lowest set column bit, zero-extended; col0 has priority.
  function automatic logic [31:0] first_col(input logic [NUM_COLS-1:0] c);
    logic [31:0] idx;
    idx = NOT_FOUND;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      if (c[i]) idx = 32'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for asynchronous level inputs.
module keypad_sync #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  // Reset preloads the live input so no artificial edge appears after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= d_i;
      sync_q <= d_i;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad.sv
// Matrix keypad scanner: each start transition runs one row-by-row pass and
// latches the first pressed key (lowest row, then lowest column).
module keypad
  import keypad_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [NUM_COLS-1:0] cols,
  output logic [NUM_ROWS-1:0] rows,
  output logic [31:0]         foundRow,
  output logic [31:0]         foundCol,
  output logic                dataReady
);

  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE_CYCLES - 1);

  logic                start_s;
  logic [NUM_COLS-1:0] cols_s;
  logic                start_edge;

  state_e               state_q, state_d;
  logic [ROW_IDX_W-1:0] row_q, row_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [31:0]          found_row_q, found_row_d;
  logic [31:0]          found_col_q, found_col_d;
  logic                 data_ready_q, data_ready_d;
  logic                 start_prev_q;

  keypad_sync #(
    .Width (1)
  ) u_start_sync (
    .clk_i (clock),
    .rst_i (reset),
    .d_i   (start),
    .q_o   (start_s)
  );

  keypad_sync #(
    .Width (NUM_COLS)
  ) u_cols_sync (
    .clk_i (clock),
    .rst_i (reset),
    .d_i   (cols),
    .q_o   (cols_s)
  );

  // Any change of the synchronised start level is a scan request.
  assign start_edge = start_s ^ start_prev_q;

  // State, row index, settle counter and latched results.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      row_q        <= '0;
      cnt_q        <= '0;
      found_row_q  <= '0;
      found_col_q  <= '0;
      data_ready_q <= 1'b0;
      start_prev_q <= start;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      cnt_q        <= cnt_d;
      found_row_q  <= found_row_d;
      found_col_q  <= found_col_d;
      data_ready_q <= data_ready_d;
      // Always track start so edges seen outside IDLE are consumed, not queued.
      start_prev_q <= start_s;
    end
  end

  // Scan sequencing: settle each row, sample, then advance or finish.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    cnt_d        = cnt_q;
    found_row_d  = found_row_q;
    found_col_d  = found_col_q;
    data_ready_d = data_ready_q;
    case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d      = StDrive;
          row_d        = '0;
          cnt_d        = '0;
          data_ready_d = 1'b0;
        end
      end
      StDrive: begin
        if (cnt_q == CntLast) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSample: begin
        if (|cols_s) begin
          found_row_d = 32'(row_q);
          found_col_d = first_col(cols_s);
          state_d     = StDone;
        end else if (row_q != ROW_LAST) begin
          row_d   = row_q + 1'b1;
          cnt_d   = '0;
          state_d = StDrive;
        end else begin
          found_row_d = NOT_FOUND;
          found_col_d = NOT_FOUND;
          state_d     = StDone;
        end
      end
      StDone: begin
        data_ready_d = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Row drive stays asserted through the sample cycle of the current row.
  always_comb begin
    rows = '0;
    if (state_q == StDrive || state_q == StSample) begin
      rows = NUM_ROWS'(1) << row_q;
    end
  end

  assign foundRow  = found_row_q;
  assign foundCol  = found_col_q;
  assign dataReady = data_ready_q;

endmodule

// File: tb/tb_keypad.sv
// Self-checking bench for keypad: a keypad matrix model drives cols from rows,
// and a scan-order reference model predicts result, latency and row sequence.
module tb_keypad;
  import keypad_pkg::*;

  localparam int unsigned Settle = 4;

  logic                         clock;
  logic                         reset;
  logic                         start;
  logic [NUM_COLS-1:0]          cols;
  logic [NUM_ROWS-1:0]          rows;
  logic [31:0]                  foundRow;
  logic [31:0]                  foundCol;
  logic                         dataReady;

  // Keypad model: either a fixed cols level or a pressed-key matrix.
  logic                         static_en;
  logic [NUM_COLS-1:0]          static_cols;
  logic [NUM_ROWS*NUM_COLS-1:0] pressed;

  int checks;
  int errors;

  // Observations from the last scan.
  int                  lat;
  int                  dr_falls;
  logic [NUM_ROWS-1:0] rows_seen[$];

  keypad #(
    .SETTLE_CYCLES (Settle)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .cols      (cols),
    .rows      (rows),
    .foundRow  (foundRow),
    .foundCol  (foundCol),
    .dataReady (dataReady)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    cols = '0;
    if (static_en) begin
      cols = static_cols;
    end else begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (rows[r]) cols = cols | pressed[r*NUM_COLS +: NUM_COLS];
      end
    end
  end

  // Reference: walk rows in order; the first row showing any column wins.
  function automatic void model(input logic st, input logic [NUM_COLS-1:0] sc,
                                input logic [NUM_ROWS*NUM_COLS-1:0] pr,
                                output logic [31:0] er, output logic [31:0] ec,
                                output int elat, output int nrows);
    logic [NUM_COLS-1:0] seen;
    bit hit;
    er    = NOT_FOUND;
    ec    = NOT_FOUND;
    nrows = NUM_ROWS;
    hit   = 0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      seen = st ? sc : pr[r*NUM_COLS +: NUM_COLS];
      if (!hit && seen != 0) begin
        hit   = 1;
        er    = r;
        nrows = r + 1;
        for (int c = NUM_COLS - 1; c >= 0; c--) if (seen[c]) ec = c;
      end
    end
    elat = 2 + 1 + nrows * (Settle + 1) + 1;
  endfunction

  // Toggle start at a falling edge, then watch until dataReady reasserts.
  task automatic do_scan(input bit second_toggle);
    logic prev_dr;
    logic init_dr;
    rows_seen.delete();
    lat      = -1;
    dr_falls = 0;
    @(negedge clock);
    init_dr = dataReady;
    prev_dr = dataReady;
    start   = ~start;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clock);
      if (second_toggle && k == 1) start = ~start;
      if (prev_dr && !dataReady) dr_falls++;
      prev_dr = dataReady;
      if (rows != 0 && (rows_seen.size() == 0 || rows_seen[$] != rows)) rows_seen.push_back(rows);
      if (dataReady && (dr_falls > 0 || !init_dr)) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    start     = 1'b0;
    static_en = 1'b1;
    static_cols = '0;
    pressed   = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    checks++;
    if (rows !== 4'b0000) begin
      errors++; $display("FAIL reset_rows: got %b expected 0000", rows);
    end
    checks++;
    if (dataReady !== 1'b0) begin
      errors++; $display("FAIL reset_dataReady: got %b expected 0", dataReady);
    end
    checks++;
    if (foundRow !== 32'd0 || foundCol !== 32'd0) begin
      errors++; $display("FAIL reset_found: got %h/%h expected 0/0", foundRow, foundCol);
    end
  endtask

  task automatic check_scan(input string name);
    logic [31:0] er, ec;
    int elat, nrows;
    model(static_en, static_cols, pressed, er, ec, elat, nrows);
    checks++;
    if (foundRow !== er || foundCol !== ec) begin
      errors++;
      $display("FAIL %s_result: got %h/%h expected %h/%h", name, foundRow, foundCol, er, ec);
    end
    checks++;
    if (lat !== elat) begin
      errors++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, elat);
    end
    checks++;
    if (rows_seen.size() != nrows) begin
      errors++;
      $display("FAIL %s_rowcount: got %0d expected %0d", name, rows_seen.size(), nrows);
    end else begin
      for (int i = 0; i < nrows; i++) begin
        checks++;
        if (rows_seen[i] !== NUM_ROWS'(1 << i)) begin
          errors++;
          $display("FAIL %s_rowseq%0d: got %b expected %b", name, i, rows_seen[i],
                   NUM_ROWS'(1 << i));
        end
      end
    end
    @(negedge clock);
    checks++;
    if (rows !== 4'b0000 || dataReady !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle: got rows=%b dr=%b expected 0000/1", name, rows, dataReady);
    end
  endtask

  task automatic test_static_key();
    static_en = 1'b1; static_cols = 3'b001;
    do_scan(0);
    check_scan("static001");
  endtask

  task automatic test_matrix_key();
    static_en = 1'b0; pressed = '0;
    pressed[2*NUM_COLS + 2] = 1'b1;
    do_scan(0);
    check_scan("key_r2c2");
  endtask

  task automatic test_no_key();
    static_en = 1'b1; static_cols = 3'b000;
    do_scan(0);
    check_scan("nokey");
  endtask

  task automatic test_col_priority();
    static_en = 1'b1; static_cols = 3'b110;
    do_scan(0);
    check_scan("cols110");
  endtask

  task automatic test_back_to_back();
    static_en = 1'b1; static_cols = 3'b010;
    do_scan(1);
    checks++;
    if (dr_falls !== 1) begin
      errors++; $display("FAIL b2b_drfalls: got %0d expected 1", dr_falls);
    end
    check_scan("b2b");
    repeat (40) @(negedge clock);
    checks++;
    if (dataReady !== 1'b1 || rows !== 4'b0000 || foundRow !== 32'd0 || foundCol !== 32'd1) begin
      errors++;
      $display("FAIL b2b_norescan: got dr=%b rows=%b %h/%h expected 1/0000/0/1",
               dataReady, rows, foundRow, foundCol);
    end
  endtask

  task automatic test_reset_midscan();
    bit seen;
    static_en = 1'b1; static_cols = 3'b000;
    seen = 0;
    @(negedge clock);
    start = ~start;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (rows == 4'b0010) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL midreset_row1: got no row1 drive expected 0010");
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (rows !== 4'b0000 || dataReady !== 1'b0 || foundRow !== 32'd0 || foundCol !== 32'd0) begin
      errors++;
      $display("FAIL midreset_vals: got rows=%b dr=%b %h/%h expected 0000/0/0/0",
               rows, dataReady, foundRow, foundCol);
    end
    static_en = 1'b0; pressed = '0;
    pressed[1*NUM_COLS + 0] = 1'b1;
    do_scan(0);
    check_scan("postreset");
  endtask

  task automatic test_random();
    int nkeys;
    static_en = 1'b0;
    for (int it = 0; it < 8; it++) begin
      pressed = '0;
      nkeys = $urandom_range(0, 3);
      for (int j = 0; j < nkeys; j++) pressed[$urandom_range(0, NUM_ROWS*NUM_COLS-1)] = 1'b1;
      do_scan(0);
      check_scan($sformatf("rand%0d", it));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_static_key();
    test_matrix_key();
    test_no_key();
    test_col_priority();
    test_back_to_back();
    test_reset_midscan();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
